// File: rtl/ofdm_rx_pkg.sv
// Shared OFDM receiver definitions: standard select, FFT sizes, data counts
// and the null/pilot subcarrier tables for 802.11a and 802.16d.
package ofdm_rx_pkg;

  typedef enum logic [0:0] {
    STD_11A = 1'b0,
    STD_16D = 1'b1
  } std_e;

  typedef enum logic [1:0] {
    BIN_DATA,
    BIN_PILOT,
    BIN_NULL
  } bin_class_e;

  localparam int FFT_N_11A  = 64;
  localparam int FFT_N_16D  = 256;
  localparam int DATA_N_11A = 48;
  localparam int DATA_N_16D = 192;

  localparam int NULL_LO_11A = 27;
  localparam int NULL_HI_11A = 37;
  localparam int NULL_LO_16D = 101;
  localparam int NULL_HI_16D = 155;

  localparam int PILOT_N_11A = 4;
  localparam int PILOT_N_16D = 8;
  localparam logic [PILOT_N_11A-1:0][7:0] PILOTS_11A =
    {8'd57, 8'd43, 8'd21, 8'd7};
  localparam logic [PILOT_N_16D-1:0][7:0] PILOTS_16D =
    {8'd243, 8'd218, 8'd193, 8'd168, 8'd88, 8'd63, 8'd38, 8'd13};

  // Encodings 2 and 3 fall back to 802.11a.
  function automatic std_e decode_std(input logic [1:0] std_raw);
    return (std_raw == 2'd1) ? STD_16D : STD_11A;
  endfunction

  function automatic logic [7:0] last_bin(input std_e s);
    return (s == STD_16D) ? 8'(FFT_N_16D - 1) : 8'(FFT_N_11A - 1);
  endfunction

endpackage

// File: rtl/pilots_remove_bin_map.sv
// Combinational subcarrier classifier: FFT bin index + standard -> DATA/PILOT/NULL.
module pilots_remove_bin_map
  import ofdm_rx_pkg::*;
(
  input  logic [7:0]  bin,
  input  std_e        std_sel,
  output bin_class_e  cls
);

  always_comb begin
    // NOTE: default first so every path assigns cls and no latch is inferred.
    cls = BIN_DATA;
    if (std_sel == STD_16D) begin
      for (int i = 0; i < PILOT_N_16D; i++)
        if (bin == PILOTS_16D[i]) cls = BIN_PILOT;
      if (bin == 8'd0 || (bin >= 8'(NULL_LO_16D) && bin <= 8'(NULL_HI_16D)))
        cls = BIN_NULL;
    end else begin
      for (int i = 0; i < PILOT_N_11A; i++)
        if (bin == PILOTS_11A[i]) cls = BIN_PILOT;
      if (bin == 8'd0 || (bin >= 8'(NULL_LO_11A) && bin <= 8'(NULL_HI_11A)))
        cls = BIN_NULL;
    end
  end

endmodule

// File: rtl/pilots_remove.sv
// Strips pilot and null subcarriers from a Wishbone-style FFT bin stream.
// Define PILOTS_REMOVE_PILOT_OUT_EN to expose pilots on PIL_DAT_O/PIL_STB_O.
module pilots_remove
  import ofdm_rx_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  input  logic [1:0]    STD
`ifdef PILOTS_REMOVE_PILOT_OUT_EN
  ,
  output logic [DW-1:0] PIL_DAT_O,
  output logic          PIL_STB_O
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e     state;
  logic [7:0] bin;
  std_e       std_q;
  std_e       std_cur;
  bin_class_e cls;
  logic       wr_req;
  logic       is_data;
  logic       in_xfer;
  logic       out_xfer;
  logic       stb_nxt;

  // Bin 0 is where the new standard is sampled, so classify it with the live input.
  assign std_cur = (bin == 8'd0) ? decode_std(STD) : std_q;

  pilots_remove_bin_map u_bin_map (
    .bin     (bin),
    .std_sel (std_cur),
    .cls     (cls)
  );

  assign is_data  = (cls == BIN_DATA);
  assign wr_req   = CYC_I & STB_I & WE_I;
  assign ACK_O    = wr_req & (~STB_O | ACK_I | ~is_data);
  assign in_xfer  = wr_req & ACK_O;
  assign out_xfer = STB_O & ACK_I;
  assign stb_nxt  = (in_xfer & is_data) | (STB_O & ~ACK_I);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      bin   <= 8'd0;
      std_q <= STD_11A;
    end else if (!CYC_I) begin
      bin <= 8'd0;
    end else if (in_xfer) begin
      if (bin == 8'd0) std_q <= std_cur;
      bin <= (bin == last_bin(std_cur)) ? 8'd0 : bin + 8'd1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O <= '0;
      STB_O <= 1'b0;
    end else begin
      if (in_xfer && is_data) DAT_O <= DAT_I;
      STB_O <= stb_nxt;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= S_IDLE;
      CYC_O <= 1'b0;
      WE_O  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (CYC_I) begin
          state <= S_RUN;
          CYC_O <= 1'b1;
          WE_O  <= 1'b1;
        end
        S_RUN: if (!CYC_I) begin
          // Look at the next-cycle strobe: a sample acked right now needs no flush.
          state <= stb_nxt ? S_FLUSH : S_IDLE;
          CYC_O <= stb_nxt;
          WE_O  <= stb_nxt;
        end
        S_FLUSH: begin
          if (CYC_I) begin
            state <= S_RUN;
          end else if (out_xfer) begin
            state <= S_IDLE;
            CYC_O <= 1'b0;
            WE_O  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          CYC_O <= 1'b0;
          WE_O  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PILOTS_REMOVE_PILOT_OUT_EN
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      PIL_DAT_O <= '0;
      PIL_STB_O <= 1'b0;
    end else begin
      PIL_STB_O <= in_xfer & (cls == BIN_PILOT);
      if (in_xfer && cls == BIN_PILOT) PIL_DAT_O <= DAT_I;
    end
  end
`endif

endmodule

// File: tb/tb_pilots_remove.sv
// Self-checking bench for pilots_remove: arithmetic subcarrier model plus a
// per-cycle scoreboard, with directed symbols and literal spot checks.
`timescale 1ns/1ps
module tb_pilots_remove;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = '0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O;
  logic        ACK_I = 1'b1;
  logic [1:0]  STD = 2'd0;
`ifdef PILOTS_REMOVE_PILOT_OUT_EN
  logic [31:0] PIL_DAT_O;
  logic        PIL_STB_O;
`endif

  pilots_remove #(.DW(32)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O),
    .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .STD(STD)
`ifdef PILOTS_REMOVE_PILOT_OUT_EN
    , .PIL_DAT_O(PIL_DAT_O), .PIL_STB_O(PIL_STB_O)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Subcarrier model from the symmetric band layout around DC.
  typedef enum int {M_DATA, M_PILOT, M_NULL} mcls_e;
  function automatic mcls_e model_class(input int s, input int b);
    int d;
    if (s == 0) begin
      d = (b > 32) ? b - 32 : 32 - b;
      if (b == 0 || d <= 5) return M_NULL;
      if (d == 11 || d == 25) return M_PILOT;
      return M_DATA;
    end
    d = (b > 128) ? b - 128 : 128 - b;
    if (b == 0 || (b >= 101 && b <= 155)) return M_NULL;
    if (d >= 40 && (d - 40) % 25 == 0) return M_PILOT;
    return M_DATA;
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  logic [31:0] got_pil[$];
  int          m_bin = 0;
  int          m_std = 0;
  bit          pil_exp = 1'b0;
  logic [31:0] pil_exp_dat = '0;

  always @(negedge CLK_I) begin
    int    s_eff;
    mcls_e c;
    logic  exp_ack;
    if (RST_I) begin
      exp_q.delete();
      m_bin   = 0;
      m_std   = 0;
      pil_exp = 1'b0;
    end else begin
      if (exp_q.size() > 0) begin
        check("stb_o_pending", STB_O, 1);
        check("dat_o", DAT_O, exp_q[0]);
      end else begin
        check("stb_o_idle", STB_O, 0);
      end
      if (STB_O && ACK_I) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        got.push_back(DAT_O);
      end
      s_eff   = (m_bin == 0) ? ((STD == 2'd1) ? 1 : 0) : m_std;
      c       = model_class(s_eff, m_bin);
      exp_ack = CYC_I & STB_I & WE_I & (!STB_O || ACK_I || c != M_DATA);
      check("ack_o", ACK_O, exp_ack);
`ifdef PILOTS_REMOVE_PILOT_OUT_EN
      check("pil_stb_o", PIL_STB_O, pil_exp);
      if (pil_exp) check("pil_dat_o", PIL_DAT_O, pil_exp_dat);
      if (PIL_STB_O) got_pil.push_back(PIL_DAT_O);
`endif
      pil_exp = 1'b0;
      if (!CYC_I) begin
        m_bin = 0;
      end else if (CYC_I && STB_I && WE_I && ACK_O) begin
        if (m_bin == 0) m_std = s_eff;
        if (c == M_DATA) exp_q.push_back(DAT_I);
        if (c == M_PILOT) begin
          pil_exp     = 1'b1;
          pil_exp_dat = DAT_I;
        end
        m_bin = (m_bin == ((m_std == 1) ? 255 : 63)) ? 0 : m_bin + 1;
      end
    end
  end

  // Output-side backpressure: hold ACK_I low while a chosen sample is presented.
  int st_val[2]  = '{-1, -1};
  int st_left[2] = '{0, 0};
  always @(posedge CLK_I) begin
    #1;
    ACK_I = 1'b1;
    for (int k = 0; k < 2; k++)
      if (STB_O && int'(DAT_O[15:0]) == st_val[k] && st_left[k] > 0) begin
        ACK_I = 1'b0;
        st_left[k]--;
      end
  end

  int wait_cycles[256];

  task automatic beat(input int b, input logic [31:0] d);
    int w = 0;
    DAT_I = d; CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1;
    forever begin
      @(negedge CLK_I);
      if (ACK_O === 1'b1) break;
      w++;
      if (w > 300) begin
        check("ack_timeout", w, 0);
        break;
      end
    end
    wait_cycles[b] = w;
    @(posedge CLK_I); #1;
  endtask

  task automatic send(input int sym, input int nbeats, input int sw_at, input logic [1:0] sw_std);
    for (int b = 0; b < nbeats; b++) begin
      if (b == sw_at) STD = sw_std;
      beat(b, (sym << 16) | b);
    end
  endtask

  task automatic end_burst();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  function automatic int got_at(input int i);
    if (i < got.size()) return int'(got[i][15:0]);
    return -1;
  endfunction

  function automatic int count_tag(input int t);
    int n = 0;
    foreach (got[i]) if (int'(got[i][31:16]) == t) n++;
    return n;
  endfunction

  initial begin
    int bad;
    int got_nz;
    // Reset values
    idle(2);
    check("rst_dat_o", DAT_O, 0);
    check("rst_stb_o", STB_O, 0);
    check("rst_cyc_o", CYC_O, 0);
    check("rst_we_o",  WE_O,  0);
    @(negedge CLK_I); #2; RST_I = 1'b0;
    idle(2);

    // CYC_O registered one cycle after CYC_I; STB_I ignored while WE_I low
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b0;
    @(negedge CLK_I);
    check("cyc_o_not_yet", CYC_O, 0);
    @(negedge CLK_I);
    check("cyc_o_run", CYC_O, 1);
    check("we_o_run",  WE_O,  1);
    idle(3);

    // 802.11a symbol, bin index as data
    got.delete();
    STD = 2'd0;
    send(1, 64, -1, 2'd0);
    end_burst(); idle(4);
    check("a_count", got.size(), 48);
    check("a_out0",  got_at(0),  1);
    check("a_out5",  got_at(5),  6);
    check("a_out6",  got_at(6),  8);
    check("a_out18", got_at(18), 20);
    check("a_out19", got_at(19), 22);
    check("a_out23", got_at(23), 26);
    check("a_out24", got_at(24), 38);
    check("a_out28", got_at(28), 42);
    check("a_out29", got_at(29), 44);
    check("a_out41", got_at(41), 56);
    check("a_out42", got_at(42), 58);
    check("a_out47", got_at(47), 63);
    check("a_cyc_o_idle", CYC_O, 0);

    // 802.16d symbol
    got.delete();
    STD = 2'd1;
    send(2, 256, -1, 2'd1);
    end_burst(); idle(4);
    check("d_count", got.size(), 192);
    bad = 0;
    foreach (got[i]) begin
      got_nz = int'(got[i][15:0]);
      if (got_nz == 0 || got_nz == 13 || got_nz == 88 || got_nz == 243 ||
          (got_nz >= 101 && got_nz <= 155)) bad++;
    end
    check("d_forbidden", bad, 0);

    // Backpressure: stall at bins 3 and 26, then at bin 6
    got.delete();
    STD = 2'd0;
    st_val  = '{3, 26};
    st_left = '{10, 5};
    send(3, 64, -1, 2'd0);
    end_burst(); idle(4);
    check("stall_count", got.size(), 48);
    check("stall_wait3", wait_cycles[3], 0);
    check("stall_wait4", wait_cycles[4], 10);
    bad = 0;
    for (int b = 27; b <= 37; b++) bad += wait_cycles[b];
    check("stall_null_wait", bad, 0);
    got.delete();
    st_val  = '{6, -1};
    st_left = '{3, 0};
    send(4, 64, -1, 2'd0);
    end_burst(); idle(4);
    check("stall_pilot_wait7", wait_cycles[7], 0);
    check("stall_wait8", wait_cycles[8], 2);
    check("stall2_count", got.size(), 48);

    // STD changed mid-symbol, then back-to-back 802.16d symbol
    got.delete();
    STD = 2'd0;
    send(5, 64, 30, 2'd1);
    send(6, 256, -1, 2'd1);
    end_burst(); idle(4);
    check("sw_count_a", count_tag(5), 48);
    check("sw_count_d", count_tag(6), 192);

    // CYC_I dropped at bin 20 with sample pending -> flush
    got.delete();
    STD = 2'd0;
    st_val  = '{20, -1};
    st_left = '{3, 0};
    send(7, 21, -1, 2'd0);
    end_burst();
    @(negedge CLK_I);
    check("flush_cyc_o_1", CYC_O, 1);
    @(negedge CLK_I);
    check("flush_cyc_o_2", CYC_O, 1);
    check("flush_stb_o", STB_O, 1);
    check("flush_dat_o", DAT_O[15:0], 20);
    bad = 0;
    while (STB_O && bad < 20) begin
      @(negedge CLK_I);
      bad++;
    end
    check("flush_drained", STB_O, 0);
    check("flush_cyc_o_low", CYC_O, 0);
    check("flush_we_o_low",  WE_O,  0);
    check("flush_last", got_at(got.size() - 1), 20);
    idle(2);
    got.delete();
    send(8, 64, -1, 2'd0);
    end_burst(); idle(4);
    check("after_flush_count", got.size(), 48);
    check("after_flush_first", got_at(0), 1);

    // Reset pulse at bin 40
    send(9, 41, -1, 2'd0);
    RST_I = 1'b1;
    #1;
    check("rst40_dat_o", DAT_O, 0);
    check("rst40_stb_o", STB_O, 0);
    check("rst40_cyc_o", CYC_O, 0);
    check("rst40_we_o",  WE_O,  0);
    end_burst();
    idle(2);
    @(negedge CLK_I); #2; RST_I = 1'b0;
    idle(2);
    got.delete();
    got_pil.delete();
    send(10, 64, -1, 2'd0);
    end_burst(); idle(4);
    check("rst_restart_count", got.size(), 48);
    check("rst_restart_first", got_at(0), 1);
`ifdef PILOTS_REMOVE_PILOT_OUT_EN
    check("pil_count", got_pil.size(), 4);
    if (got_pil.size() == 4) begin
      check("pil0", got_pil[0][15:0], 7);
      check("pil1", got_pil[1][15:0], 21);
      check("pil2", got_pil[2][15:0], 43);
      check("pil3", got_pil[3][15:0], 57);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
